// File: rtl/seqdet_pkg.sv
// Shared constants for the programmable serial-pattern detector: reset-time
// defaults (the legacy "101" overlap detector) and the length-port width helper.
package seqdet_pkg;

    localparam logic [7:0] SEQDET_DEF_PAT = 8'b0000_0101;
    localparam int         SEQDET_DEF_LEN = 3;
    localparam bit         SEQDET_DEF_OVL = 1'b1;

    // Length fields must hold 0..N inclusive.
    function automatic int seqdet_lw(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/seqdet_match_cmp.sv
// Combinational length-masked pattern compare plus history-fill check;
// produces the raw match before valid/config-load gating.
module seqdet_match_cmp
    import seqdet_pkg::*;
#(
    parameter  int N  = 8,
    localparam int LW = seqdet_lw(N)
) (
    input  logic [N-1:0]  w,
    input  logic [N-1:0]  pat,
    input  logic [LW-1:0] len,
    input  logic [LW-1:0] fill,
    output logic          hit
);

    logic [N-1:0] diff;
    logic         fill_ok;

    always_comb begin
        diff = '0;
        for (int i = 0; i < N; i++) begin
            if (i < int'(len)) diff[i] = w[i] ^ pat[i];
        end
    end

    // fill >= len-1 written as fill+1 >= len so len=0 cannot underflow.
    assign fill_ok = ({1'b0, fill} + (LW+1)'(1)) >= {1'b0, len};
    assign hit     = (len != '0) && fill_ok && (diff == '0);

endmodule

// File: rtl/seq_detector_mealy.sv
// Runtime-programmable Mealy serial-pattern detector with overlap control.
// Optional saturating match counter enabled by `define SEQDET_MATCH_CNT_EN.
module seq_detector_mealy
    import seqdet_pkg::*;
#(
    parameter  int           N       = 8,
    parameter  int           CNT_W   = 16,
    parameter  logic [N-1:0] DEF_PAT = N'(SEQDET_DEF_PAT),
    parameter  int           DEF_LEN = SEQDET_DEF_LEN,
    parameter  bit           DEF_OVL = SEQDET_DEF_OVL,
    localparam int           LW      = seqdet_lw(N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              x,
    input  logic              x_valid,
    input  logic              cfg_load,
    input  logic [N-1:0]      cfg_pat,
    input  logic [LW-1:0]     cfg_len,
    input  logic              cfg_ovl,
    output logic              y
`ifdef SEQDET_MATCH_CNT_EN
    ,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  match_cnt
`endif
);

    // The oldest history bit never reaches the window, so only N-1 are kept.
    logic [N-2:0]  h;
    logic [N-1:0]  w;
    logic [N-1:0]  pat_r;
    logic [LW-1:0] len_r;
    logic [LW-1:0] len_eff;
    logic [LW-1:0] fill;
    logic          ovl_r;
    logic          hit;

    assign w       = {h, x};
    assign len_eff = (len_r > LW'(N)) ? LW'(N) : len_r;

    seqdet_match_cmp #(.N(N)) u_cmp (
        .w    (w),
        .pat  (pat_r),
        .len  (len_eff),
        .fill (fill),
        .hit  (hit)
    );

    assign y = !rst && x_valid && !cfg_load && hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            h     <= '0;
            fill  <= '0;
            pat_r <= DEF_PAT;
            len_r <= LW'(DEF_LEN);
            ovl_r <= DEF_OVL;
        end else if (cfg_load) begin
            pat_r <= cfg_pat;
            len_r <= cfg_len;
            ovl_r <= cfg_ovl;
            fill  <= '0;
        end else if (x_valid) begin
            h <= w[N-2:0];
            // Non-overlap: a match consumes its bits, next match needs L fresh ones.
            if (y && !ovl_r)
                fill <= '0;
            else if (fill != LW'(N))
                fill <= fill + LW'(1);
        end
    end

`ifdef SEQDET_MATCH_CNT_EN
    logic [CNT_W-1:0] cnt_r;

    always_ff @(posedge clk) begin
        if (rst)
            cnt_r <= '0;
        else if (cnt_clr)
            cnt_r <= CNT_W'(y);
        else if (y && (cnt_r != '1))
            cnt_r <= cnt_r + CNT_W'(1);
    end

    assign match_cnt = cnt_r;
`endif

endmodule

// File: tb/tb_seq_detector_mealy.sv
// Bench for seq_detector_mealy: hand-computed vector table, then a random run
// checked against a queue-based reference model.
module tb_seq_detector_mealy;

    localparam int N     = 8;
    localparam int CNT_W = 2;
    localparam int LW    = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          x = 1'b0, x_valid = 1'b0, cfg_load = 1'b0, cfg_ovl = 1'b0;
    logic [N-1:0]  cfg_pat = '0;
    logic [LW-1:0] cfg_len = '0;
    logic          y;
`ifdef SEQDET_MATCH_CNT_EN
    logic             cnt_clr = 1'b0;
    logic [CNT_W-1:0] match_cnt;
`endif

    always #5 clk = ~clk;

    seq_detector_mealy #(.N(N), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .x        (x),
        .x_valid  (x_valid),
        .cfg_load (cfg_load),
        .cfg_pat  (cfg_pat),
        .cfg_len  (cfg_len),
        .cfg_ovl  (cfg_ovl),
        .y        (y)
`ifdef SEQDET_MATCH_CNT_EN
        ,
        .cnt_clr  (cnt_clr),
        .match_cnt(match_cnt)
`endif
    );

    typedef struct {
        logic       r, ld;
        logic [7:0] pat;
        logic [3:0] len;
        logic       ovl, xv, xb, clr, ey, ck;
        logic [1:0] ec;
    } vec_t;

    typedef struct {
        logic       ey, ck;
        logic [1:0] ec;
        int         id;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   nvec = 0;
    int   nerr = 0;

    // Reference model state
    logic [7:0] m_pat;
    logic [3:0] m_len;
    logic       m_ovl;
    logic [1:0] m_cnt;
    bit         hist[$];

    task automatic add(input logic r, ld, input logic [7:0] p, input logic [3:0] l,
                       input logic o, xv, xb, clr, ey, ck, input logic [1:0] ec);
        vecs.push_back('{r, ld, p, l, o, xv, xb, clr, ey, ck, ec});
    endtask
    task automatic dat(input logic xb, ey);
        add(0, 0, 8'h00, 4'd0, 0, 1, xb, 0, ey, 0, 2'd0);
    endtask
    task automatic idl(input logic ck, input logic [1:0] ec);
        add(0, 0, 8'h00, 4'd0, 0, 0, 0, 0, 0, ck, ec);
    endtask
    task automatic lod(input logic [7:0] p, input logic [3:0] l, input logic o);
        add(0, 1, p, l, o, 0, 0, 0, 0, 0, 2'd0);
    endtask

    task automatic drive(input vec_t v, input int id);
        @(posedge clk);
        #1;
        rst      = v.r;
        cfg_load = v.ld;
        cfg_pat  = v.pat;
        cfg_len  = v.len;
        cfg_ovl  = v.ovl;
        x_valid  = v.xv;
        x        = v.xb;
`ifdef SEQDET_MATCH_CNT_EN
        cnt_clr  = v.clr;
`endif
        sb.push_back('{v.ey, v.ck, v.ec, id});
    endtask

    task automatic mstep(input logic r, ld, input logic [7:0] p, input logic [3:0] l,
                         input logic o, xv, xb, clr, output logic ey, output logic [1:0] ec);
        int L;
        ec = m_cnt;
        ey = 1'b0;
        if (r) begin
            hist.delete();
            m_pat = 8'h05; m_len = 4'd3; m_ovl = 1'b1; m_cnt = 2'd0;
        end else begin
            if (ld) begin
                m_pat = p; m_len = l; m_ovl = o;
                hist.delete();
            end else if (xv) begin
                L = (m_len > 4'd8) ? 8 : int'(m_len);
                hist.push_back(xb);
                if (hist.size() > 8) hist.delete(0);
                if (L != 0 && hist.size() >= L) begin
                    ey = 1'b1;
                    for (int k = 0; k < L; k++)
                        if (hist[hist.size()-1-k] != m_pat[k]) ey = 1'b0;
                end
                if (ey && !m_ovl) hist.delete();
            end
            if (clr) m_cnt = ey ? 2'd1 : 2'd0;
            else if (ey && m_cnt != 2'd3) m_cnt = m_cnt + 2'd1;
        end
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            nvec++;
            if (y !== e.ey) begin
                nerr++;
                $display("FAIL y vec %0d: got %b want %b", e.id, y, e.ey);
            end
`ifdef SEQDET_MATCH_CNT_EN
            if (e.ck) begin
                nvec++;
                if (match_cnt !== e.ec) begin
                    nerr++;
                    $display("FAIL match_cnt vec %0d: got %0d want %0d", e.id, match_cnt, e.ec);
                end
            end
`endif
        end
    end

    initial begin
        vec_t v;
        int   base;
        // Reset, with a valid 1 presented during reset: y must stay 0
        add(1, 0, 8'h00, 4'd0, 0, 1, 1, 0, 0, 0, 2'd0);
        add(1, 0, 8'h00, 4'd0, 0, 0, 0, 0, 0, 1, 2'd0);
        // Defaults: 101, overlapping
        dat(1,0); dat(0,0); dat(1,1); dat(0,0); dat(1,1);
        idl(1, 2'd2);
        // Non-overlap 101
        lod(8'h05, 4'd3, 0);
        dat(1,0); dat(0,0); dat(1,1); dat(0,0); dat(1,0);
        lod(8'h05, 4'd3, 0);
        dat(1,0); dat(0,0); dat(1,1); dat(0,0); dat(1,0); dat(0,0); dat(1,1);
        idl(1, 2'd3);
        // Counter clear coincident with a match -> 1
        lod(8'h05, 4'd3, 1);
        dat(1,0); dat(0,0);
        add(0, 0, 8'h00, 4'd0, 0, 1, 1, 1, 1, 0, 2'd0);
        idl(1, 2'd1);
        // L=8 pattern 1101_0011 with a 2-cycle gap
        lod(8'hD3, 4'd8, 1);
        dat(1,0); dat(1,0); dat(0,0); dat(1,0);
        idl(0, 2'd0); idl(0, 2'd0);
        dat(0,0); dat(0,0); dat(1,0); dat(1,1);
        idl(1, 2'd2);
        // L=1, pattern 1
        lod(8'h01, 4'd1, 1);
        dat(1,1); dat(1,1); dat(0,0); dat(1,1);
        idl(1, 2'd3);
        // L=0 disables, even with an all-zero pattern
        lod(8'h00, 4'd0, 1);
        dat(0,0); dat(0,0); dat(1,0); dat(0,0);
        // cfg_len=15 acts as L=8
        lod(8'hD3, 4'd15, 1);
        dat(1,0); dat(1,0); dat(0,0); dat(1,0); dat(0,0); dat(0,0); dat(1,0); dat(1,1);
        // Reset mid-sequence discards history
        lod(8'h05, 4'd3, 1);
        dat(1,0); dat(0,0);
        add(1, 0, 8'h00, 4'd0, 0, 0, 0, 0, 0, 0, 2'd0);
        dat(1,0); dat(0,0); dat(1,1);
        // cfg_load coincident with final pattern bit: bit ignored, fill cleared
        dat(1,0); dat(0,0);
        add(0, 1, 8'h05, 4'd3, 1, 1, 1, 0, 0, 0, 2'd0);
        dat(1,0); dat(0,0); dat(1,1);

        foreach (vecs[i]) drive(vecs[i], i);

        // Random phase against the reference model, starting from reset
        base = vecs.size();
        for (int i = 0; i < 400; i++) begin
            v.r   = (i == 0) || ($urandom_range(0, 99) == 0);
            v.ld  = ($urandom_range(0, 99) < 4);
            v.pat = 8'($urandom);
            v.len = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(5, 15))
                                                : 4'($urandom_range(0, 4));
            v.ovl = 1'($urandom);
            v.xv  = ($urandom_range(0, 3) != 0);
            v.xb  = 1'($urandom);
            v.clr = ($urandom_range(0, 19) == 0);
            v.ck  = !v.r || i > 0;
            mstep(v.r, v.ld, v.pat, v.len, v.ovl, v.xv, v.xb, v.clr, v.ey, v.ec);
`ifndef SEQDET_MATCH_CNT_EN
            v.clr = 1'b0;
`endif
            drive(v, base + i);
        end

        @(posedge clk);
        #1;
        x_valid  = 1'b0;
        cfg_load = 1'b0;
        rst      = 1'b0;
        for (int t = 0; t < 10 && sb.size() > 0; t++) @(negedge clk);
        #1;
        if (sb.size() > 0) begin
            nerr++;
            $display("FAIL drain: %0d expected results still pending, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
